multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback cycles, and drives every datapath enable and mux select.
- Drives the 2-bit ALU operation code to the ALU control decoder: 00=add, 01=sub, 10=use funct, 11=add immediate.
- Stalls on a memory ready handshake and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback data select: 1=MDR, 0=ALUOut.
- reg_dst  out  1  destination register select: 1=rd, 0=rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B select: 00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- alu_op  out  2  to ALU control.
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- retire  out  1  one-cycle pulse when an instruction completes.
- instr_count  out  CNT_W  retired-instruction count.
- state  out  4  current state, for debug.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11
  - codes 12-15 are unused and go to FETCH.
- Reset (rst_n=0, asynchronous): state=FETCH and instr_count=0. While rst_n=0, all enables, retire and illegal are forced to 0; selects read 0.
- Outputs are decoded combinationally from the registered state, plus mem_ready and opcode as noted. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 0x00→EXEC; 0x23 or 0x2B→MEM_ADDR; 0x04→BRANCH; 0x02→JUMP; 0x08→ADDI_EX.
  - Any other opcode: illegal=1 this cycle, next state FETCH, no retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_READ if opcode=0x23, else MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1. Next state FETCH.
- MEM_WRITE: mem_write=1, iord=1. Holds until mem_ready; retire=mem_ready; then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retire=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, retire=1. Next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=11. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next state FETCH.
- Minimum cycles per instruction, with mem_ready=1 throughout: lw 5; sw, R-type and addi 4; beq and j 3.
- instr_count increments on each clock edge where retire=1; it wraps from 2^CNT_W-1 to 0 with no flag.
- mem_read and mem_write are never asserted in the same cycle; neither is asserted outside the listed states.
- Reset asserted in any state, including mid-wait, returns to FETCH immediately. No partial write completes after reset.
- opcode is sampled only in DECODE and MEM_ADDR. The instruction register is stable there because ir_write=0.

Test Plan:
- lw (opcode 0x23), mem_ready=1 always → states 0,1,2,3,4,0; exactly one retire pulse, in state 4, with reg_write=1 and mem_to_reg=1; instr_count 0→1.
- sw (0x2B) with mem_ready low for 3 cycles in MEM_WRITE → mem_write held high 4 cycles; retire on the 4th only; reg_write never asserted.
- R-type (0x00) then beq (0x04) → alu_op=10 in EXEC and 01 in BRANCH; pc_write_cond=1 only in BRANCH; total 7 cycles; instr_count=2.
- Opcode 0x3F → illegal=1 for one cycle in DECODE, return to FETCH, no retire, instr_count unchanged.
- rst_n pulsed low mid-MEM_READ → state=0 and instr_count=0 asynchronously, all enables 0 during reset; after release, normal fetch with mem_read=1.
- CNT_W=4, 17 back-to-back jumps (0x02) → each takes 3 cycles; instr_count wraps 15→0 and ends at 1.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM for a multicycle MIPS datapath. Sequences
//                fetch/decode/execute/memory/writeback, drives every datapath
//                enable and mux select, stalls on the memory ready handshake
//                and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;

    // ALU operation codes handed to the ALU control decoder
    localparam logic [1:0] C_ALU_ADD   = 2'b00;
    localparam logic [1:0] C_ALU_SUB   = 2'b01;
    localparam logic [1:0] C_ALU_FUNCT = 2'b10;
    localparam logic [1:0] C_ALU_ADDI  = 2'b11;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;

    assign state       = r_state;
    assign instr_count = r_count;

    // State register; reset returns to FETCH from anywhere, including mid-wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter, wraps silently at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (retire) begin
            r_count <= r_count + C_CNT_ONE;
        end
    end

    // Next-state and output decode; outputs held at zero while in reset so no
    // enable (including the FETCH read request) leaks out during reset
    always_comb begin
        w_next_state  = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = C_ALU_ADD;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        retire        = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 computed in the ALU while memory returns the instruction
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_b = 2'b11;
                case (opcode)
                    C_OP_RTYPE:       w_next_state = S_EXEC;
                    C_OP_LW, C_OP_SW: w_next_state = S_MEM_ADDR;
                    C_OP_BEQ:         w_next_state = S_BRANCH;
                    C_OP_J:           w_next_state = S_JUMP;
                    C_OP_ADDI:        w_next_state = S_ADDI_EX;
                    default: begin
                        illegal      = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next_state = (opcode == C_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                // Store retires only in the cycle the memory accepts it
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
                w_next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = C_ALU_FUNCT;
                w_next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = C_ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
                w_next_state  = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = C_ALU_ADDI;
                w_next_state = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            illegal       = 1'b0;
            retire        = 1'b0;
        end
    end

endmodule
`default_nettype wire
